// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with one outstanding imem read, stall buffering and redirect flush.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_o,
  output logic [31:0] Ins_o,
  output logic        wr_EN,
  output logic        Flush
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_hold_buf, w_pc_nxt, w_hold_nxt, w_pc_inc;
  assign w_pc_inc = r_pc + 32'd4;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_hold_buf <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_hold_buf <= w_hold_nxt;
    end
  end
  // A redirect leaves an unanswered request behind unless its response lands this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold_buf;
    if (redirect) begin
      w_pc_nxt    = redirect_pc;
      w_state_nxt = (r_state == S_HOLD || (imem_rvalid && (r_state == S_WAIT || r_state == S_DROP))) ? S_REQ : S_DROP;
    end else begin
      case (r_state)
        S_REQ: w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end else if (imem_rvalid) begin
            w_pc_nxt = w_pc_inc;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_WAIT;
          end
        end
        default: w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
      endcase
    end
  end
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    wr_EN     = 1'b0;
    Flush     = 1'b0;
    Ins_o     = '0;
    PC_o      = w_pc_inc;
    if (redirect) begin
      wr_EN    = 1'b1;
      Flush    = 1'b1;
      imem_req = (r_state == S_REQ);
    end else begin
      case (r_state)
        S_REQ: imem_req = 1'b1;
        S_WAIT: begin
          if (imem_rvalid && !stall) begin
            wr_EN     = 1'b1;
            Ins_o     = imem_rdata;
            imem_req  = 1'b1;
            imem_addr = w_pc_inc;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            wr_EN     = 1'b1;
            Ins_o     = r_hold_buf;
            imem_req  = 1'b1;
            imem_addr = w_pc_inc;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the program counter, issues one-outstanding-request reads to instruction memory, and produces the PC, instruction, write-enable and flush signals consumed by the IF/ID pipeline register. It absorbs back-pressure from ID-stage stalls by buffering a returned instruction. On branch, jump or exception redirects it inserts a bubble and discards any in-flight stale response.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  ID hazard stall; IF/ID must hold
- redirect  in  1  branch/jump/exception taken this cycle
- redirect_pc  in  32  target address, valid with redirect
- imem_req  out  1  read request, accepted by memory in the same cycle
- imem_addr  out  32  word address for imem_req
- imem_rvalid  in  1  response valid; at most one per request, latency ≥1 cycle
- imem_rdata  in  32  instruction, valid with imem_rvalid
- PC_o  out  32  PC+4 of delivered instruction, to IF/ID PC_i
- Ins_o  out  32  delivered instruction, to IF/ID Ins_i
- wr_EN  out  1  IF/ID load enable
- Flush  out  1  IF/ID flush (bubble)

## Operation
- Registers: pc (address of outstanding/held instruction), state, hold_buf[31:0].
- States: REQ, WAIT, HOLD, DROP. Reset: state=REQ, pc=RESET_PC, hold_buf=0.
- All outputs are combinational from state, registers and inputs; IF/ID samples them on the same edge. Defaults: imem_req=0, imem_addr=pc, wr_EN=0, Flush=0, Ins_o=0, PC_o=pc+4.
- Redirect has priority over everything, in every state: wr_EN=1, Flush=1, Ins_o=0; pc<=redirect_pc.
  - REQ: imem_req=1 to old pc still issues; next DROP.
  - WAIT, no rvalid: next DROP. WAIT with rvalid: data discarded; next REQ.
  - HOLD: hold_buf dropped; next REQ.
  - DROP, no rvalid: stay DROP. DROP with rvalid: next REQ.
- REQ (no redirect): imem_req=1, imem_addr=pc; next WAIT.
- WAIT (no redirect):
  - no rvalid: idle, stay.
  - rvalid & !stall: wr_EN=1, Ins_o=imem_rdata, PC_o=pc+4. Back-to-back issue: imem_req=1, imem_addr=pc+4. pc<=pc+4; stay WAIT.
  - rvalid & stall: hold_buf<=imem_rdata; next HOLD.
- HOLD (no redirect):
  - stall: wr_EN=0, stay.
  - !stall: wr_EN=1, Ins_o=hold_buf, PC_o=pc+4, imem_req=1 at pc+4; pc<=pc+4; next WAIT.
- DROP (no redirect): wait for rvalid, discard it (wr_EN=0); next REQ.
- imem_rvalid in REQ or HOLD is a protocol violation: ignored, no state change.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is passed through unchanged.

## Timing
- Reset asserted: outputs take their defaults immediately with state REQ, so imem_req=1 at RESET_PC while reset is low. Memory is held in reset alongside and ignores it; no response is generated.
- First cycle after reset release: imem_req=1 at RESET_PC.
- Memory latency L cycles from request to rvalid. The first instruction is delivered L cycles after reset release, then one instruction per L cycles.
- Redirect penalty: flush cycle, plus drain of any outstanding response, plus 1 REQ cycle, plus L.
- Stall release from HOLD: delivery in the same cycle stall falls, no extra latency.
- Reset mid-operation: outstanding and held data are discarded; restart from RESET_PC.

## Test plan
- Reset release, L=1, mem[0]=32'h20080005, mem[4]=32'h20090003 -> cycle 1: req addr 0. Cycle 2: wr_EN=1, Ins_o=32'h20080005, PC_o=4, req addr 4. Cycle 3: Ins_o=32'h20090003, PC_o=8.
- rvalid with stall=1 held 3 cycles -> wr_EN=0, imem_req=0 for 3 cycles. Cycle of stall fall: wr_EN=1, Ins_o=buffered word, req at pc+4.
- L=3, redirect to 32'h40 one cycle after request -> Flush=1, wr_EN=1, Ins_o=0. Stale response 2 cycles later: wr_EN=0. Next cycle: req addr 32'h40.
- redirect, rvalid and stall in the same cycle in WAIT -> Flush=1, data discarded. Next cycle: REQ at redirect_pc, no DROP.
- pc=32'hFFFF_FFFC delivered -> PC_o=0, next req addr 0.
- reset low while in HOLD -> wr_EN=0 and Flush=0 immediately. After release: req at RESET_PC, and the held word is never delivered.
